regfile_param_sb: RTL and testbench

- Parametrised successor to the 8x32 two-read/one-write register file used by the datapath.
- Generalised in width and depth; adds synchronous clearing, byte-lane writes, optional hardwired-zero register 0, and optional write-to-read bypass.
- Adds a per-register busy scoreboard so the control unit can track outstanding multi-cycle results before reading operands.
- Sits between decode (A1/A2 from instruction fields) and the ALU/writeback path.

---
 rtl/regfile_param_sb.sv | 174 +++++++++++++++++
 tb/tb_regfile_param_sb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param_sb
// Purpose  : Parametrised multi-port register file with a per-register busy
//            scoreboard.
//              - DEPTH x WIDTH storage, two combinational read ports, one
//                synchronous write port with byte-lane enables.
//              - Optional hardwired-zero register 0 (ZERO_REG).
//              - Optional same-cycle write-to-read forwarding (BYPASS).
//              - Busy bit per register: set by a reservation, cleared by a
//                write. A reservation and a write to the same register in
//                the same cycle leave the register busy.
//              - Addresses >= DEPTH (possible for non power-of-two DEPTH)
//                are inert: no write, no reservation, reads return 0.
// Ports    : CLK      - clock, all state updates on the rising edge
//            RESET_N  - synchronous reset, active low
//            A1, A2   - read addresses for ports 1 and 2
//            A3       - write address
//            WE3      - write enable
//            BE3      - byte-lane enables, bit i covers WD3[8i+7:8i]
//            WD3      - write data
//            RSV      - reserve request (marks RSVA busy)
//            RSVA     - register to reserve
//            RD1, RD2 - combinational read data
//            BUSY1/2  - registered busy flag of A1 / A2
//            BUSYALL  - full registered busy vector
// Revision : 1.0 - initial release
// ============================================================================
module regfile_param_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [ADDR_W-1:0]    A1,
    input  logic [ADDR_W-1:0]    A2,
    input  logic [ADDR_W-1:0]    A3,
    input  logic                 WE3,
    input  logic [WIDTH/8-1:0]   BE3,
    input  logic [WIDTH-1:0]     WD3,
    input  logic                 RSV,
    input  logic [ADDR_W-1:0]    RSVA,
    output logic [WIDTH-1:0]     RD1,
    output logic [WIDTH-1:0]     RD2,
    output logic                 BUSY1,
    output logic                 BUSY2,
    output logic [DEPTH-1:0]     BUSYALL
);

    localparam int c_NBYTES = WIDTH / 8;

    // DEPTH expressed one bit wider than an address, so that the in-range
    // test also works when DEPTH is an exact power of two.
    localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    localparam bit c_ZERO = (ZERO_REG != 0);
    localparam bit c_BYP  = (BYPASS != 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] w_wsel;       // one-hot: register written this cycle
    logic [DEPTH-1:0] w_rsel;       // one-hot: register reserved this cycle
    logic [DEPTH-1:0] w_busy_nxt;

    // An address that physically exists in the array.
    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < c_DEPTH_EXT);
    endfunction

    // An address whose content can be non-zero: exists and is not the
    // hardwired zero register.
    function automatic logic f_live(input logic [ADDR_W-1:0] a);
        return f_in_range(a) && !(c_ZERO && (a == '0));
    endfunction

    // Matching against every legal index means an out-of-range A3/RSVA
    // simply selects nothing.
    always_comb begin
        w_wsel = '0;
        w_rsel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wsel[i] = WE3 && (A3 == ADDR_W'(i));
            w_rsel[i] = RSV && (RSVA == ADDR_W'(i));
        end
        if (c_ZERO) begin
            w_wsel[0] = 1'b0;
            w_rsel[0] = 1'b0;
        end
    end

    // Clear first, then set: a reservation in the same cycle as the write
    // that retires the previous result leaves the register busy for the
    // new producer. A write with no lanes enabled still clears busy.
    always_comb begin
        w_busy_nxt = (r_busy & ~w_wsel) | w_rsel;
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int b = 0; b < c_NBYTES; b++) begin
                    if (w_wsel[i] && BE3[b]) begin
                        r_mem[i][b*8 +: 8] <= WD3[b*8 +: 8];
                    end
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_ra   [2];
    logic [WIDTH-1:0]  w_rd   [2];
    logic              w_bz   [2];

    assign w_ra[0] = A1;
    assign w_ra[1] = A2;

    for (genvar p = 0; p < 2; p++) begin : g_rport
        always_comb begin
            w_rd[p] = '0;
            if (f_live(w_ra[p])) begin
                w_rd[p] = r_mem[w_ra[p]];
                // Forward only the enabled lanes of a same-cycle write; the
                // remaining lanes keep the stored value, mirroring what the
                // register will hold after the edge.
                if (c_BYP && WE3 && (A3 == w_ra[p])) begin
                    for (int b = 0; b < c_NBYTES; b++) begin
                        if (BE3[b]) begin
                            w_rd[p][b*8 +: 8] = WD3[b*8 +: 8];
                        end
                    end
                end
            end
        end

        // Busy comes straight from registered state; a set or clear in
        // flight this cycle is not visible until after the edge.
        always_comb begin
            w_bz[p] = 1'b0;
            if (f_in_range(w_ra[p])) begin
                w_bz[p] = r_busy[w_ra[p]];
            end
        end
    end

    assign RD1     = w_rd[0];
    assign RD2     = w_rd[1];
    assign BUSY1   = w_bz[0];
    assign BUSY2   = w_bz[1];
    assign BUSYALL = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_param_sb
// Purpose  : Directed self-checking bench for regfile_param_sb. Three
//            instances cover the configurations of interest:
//              u_a : 32x8,  ZERO_REG=0, BYPASS=1
//              u_z : 32x8,  ZERO_REG=1, BYPASS=1
//              u_n : 16x6,  ZERO_REG=0, BYPASS=0
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_param_sb;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // ---------------- instance a ----------------
    logic [2:0]  a_a1, a_a2, a_a3, a_rsva;
    logic        a_we, a_rsv;
    logic [3:0]  a_be;
    logic [31:0] a_wd, a_rd1, a_rd2;
    logic        a_busy1, a_busy2;
    logic [7:0]  a_busyall;

    regfile_param_sb #(.WIDTH(32), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) u_a (
        .CLK(clk), .RESET_N(rst_n), .A1(a_a1), .A2(a_a2), .A3(a_a3),
        .WE3(a_we), .BE3(a_be), .WD3(a_wd), .RSV(a_rsv), .RSVA(a_rsva),
        .RD1(a_rd1), .RD2(a_rd2), .BUSY1(a_busy1), .BUSY2(a_busy2),
        .BUSYALL(a_busyall)
    );

    // ---------------- instance z ----------------
    logic [2:0]  z_a1, z_a2, z_a3, z_rsva;
    logic        z_we, z_rsv;
    logic [3:0]  z_be;
    logic [31:0] z_wd, z_rd1, z_rd2;
    logic        z_busy1, z_busy2;
    logic [7:0]  z_busyall;

    regfile_param_sb #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) u_z (
        .CLK(clk), .RESET_N(rst_n), .A1(z_a1), .A2(z_a2), .A3(z_a3),
        .WE3(z_we), .BE3(z_be), .WD3(z_wd), .RSV(z_rsv), .RSVA(z_rsva),
        .RD1(z_rd1), .RD2(z_rd2), .BUSY1(z_busy1), .BUSY2(z_busy2),
        .BUSYALL(z_busyall)
    );

    // ---------------- instance n ----------------
    logic [2:0]  n_a1, n_a2, n_a3, n_rsva;
    logic        n_we, n_rsv;
    logic [1:0]  n_be;
    logic [15:0] n_wd, n_rd1, n_rd2;
    logic        n_busy1, n_busy2;
    logic [5:0]  n_busyall;

    regfile_param_sb #(.WIDTH(16), .DEPTH(6), .ZERO_REG(0), .BYPASS(0)) u_n (
        .CLK(clk), .RESET_N(rst_n), .A1(n_a1), .A2(n_a2), .A3(n_a3),
        .WE3(n_we), .BE3(n_be), .WD3(n_wd), .RSV(n_rsv), .RSVA(n_rsva),
        .RD1(n_rd1), .RD2(n_rd2), .BUSY1(n_busy1), .BUSY2(n_busy2),
        .BUSYALL(n_busyall)
    );

    task automatic a_idle();
        a_a1 = '0; a_a2 = '0; a_a3 = '0; a_rsva = '0;
        a_we = 1'b0; a_rsv = 1'b0; a_be = '0; a_wd = '0;
    endtask

    task automatic z_idle();
        z_a1 = '0; z_a2 = '0; z_a3 = '0; z_rsva = '0;
        z_we = 1'b0; z_rsv = 1'b0; z_be = '0; z_wd = '0;
    endtask

    task automatic n_idle();
        n_a1 = '0; n_a2 = '0; n_a3 = '0; n_rsva = '0;
        n_we = 1'b0; n_rsv = 1'b0; n_be = '0; n_wd = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        a_idle(); z_idle(); n_idle();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_busyall !== 8'h00) begin failures++; $display("FAIL reset_a_busyall got=%h exp=%h", a_busyall, 8'h00); end
        checks++; if (z_busyall !== 8'h00) begin failures++; $display("FAIL reset_z_busyall got=%h exp=%h", z_busyall, 8'h00); end
        checks++; if (n_busyall !== 6'h00) begin failures++; $display("FAIL reset_n_busyall got=%h exp=%h", n_busyall, 6'h00); end
        checks++; if (a_rd1 !== 32'h0) begin failures++; $display("FAIL reset_a_rd1 got=%h exp=%h", a_rd1, 32'h0); end
        rst_n = 1'b1;

        // r3 <= DEADBEEF
        @(negedge clk);
        a_we = 1'b1; a_a3 = 3'd3; a_wd = 32'hDEAD_BEEF; a_be = 4'hF;
        @(negedge clk);
        a_idle(); a_a1 = 3'd3;
        #1;
        checks++; if (a_rd1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL pre_reset_r3 got=%h exp=%h", a_rd1, 32'hDEAD_BEEF); end

        // Reset pulse with a concurrent write and reservation to r5
        @(negedge clk);
        rst_n = 1'b0;
        a_we = 1'b1; a_a3 = 3'd5; a_wd = 32'hCAFE_F00D; a_be = 4'hF;
        a_rsv = 1'b1; a_rsva = 3'd5;
        @(negedge clk);
        rst_n = 1'b1;
        a_idle(); a_a1 = 3'd3; a_a2 = 3'd5;
        #1;
        checks++; if (a_rd1 !== 32'h0) begin failures++; $display("FAIL reset_clears_r3 got=%h exp=%h", a_rd1, 32'h0); end
        checks++; if (a_rd2 !== 32'h0) begin failures++; $display("FAIL reset_blocks_r5 got=%h exp=%h", a_rd2, 32'h0); end
        checks++; if (a_busyall !== 8'h00) begin failures++; $display("FAIL reset_blocks_rsv got=%h exp=%h", a_busyall, 8'h00); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_byte_lane();
        @(negedge clk);
        a_idle(); a_we = 1'b1; a_a3 = 3'd2; a_wd = 32'h1122_3344; a_be = 4'hF;
        @(negedge clk);
        a_wd = 32'hAABB_CCDD; a_be = 4'b0101;
        @(negedge clk);
        a_idle(); a_a1 = 3'd2;
        #1;
        checks++; if (a_rd1 !== 32'h11BB_33DD) begin failures++; $display("FAIL byte_lane_0101 got=%h exp=%h", a_rd1, 32'h11BB_33DD); end

        // No lanes enabled: data holds
        @(negedge clk);
        a_we = 1'b1; a_a3 = 3'd2; a_wd = 32'h0; a_be = 4'b0000;
        @(negedge clk);
        a_idle(); a_a1 = 3'd2;
        #1;
        checks++; if (a_rd1 !== 32'h11BB_33DD) begin failures++; $display("FAIL byte_lane_none got=%h exp=%h", a_rd1, 32'h11BB_33DD); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_bypass();
        @(negedge clk);
        a_idle(); a_a1 = 3'd4; a_a2 = 3'd3;
        a_we = 1'b1; a_a3 = 3'd4; a_wd = 32'h1234_5678; a_be = 4'hF;
        #1;
        checks++; if (a_rd1 !== 32'h1234_5678) begin failures++; $display("FAIL bypass_full got=%h exp=%h", a_rd1, 32'h1234_5678); end
        checks++; if (a_rd2 !== 32'h0) begin failures++; $display("FAIL bypass_other_addr got=%h exp=%h", a_rd2, 32'h0); end

        // Partial-lane forward: r4 now 12345678
        @(negedge clk);
        a_idle(); a_a2 = 3'd4;
        a_we = 1'b1; a_a3 = 3'd4; a_wd = 32'hAAAA_AAAA; a_be = 4'b0011;
        #1;
        checks++; if (a_rd2 !== 32'h1234_AAAA) begin failures++; $display("FAIL bypass_partial got=%h exp=%h", a_rd2, 32'h1234_AAAA); end
        @(negedge clk);
        a_idle(); a_a1 = 3'd4;
        #1;
        checks++; if (a_rd1 !== 32'h1234_AAAA) begin failures++; $display("FAIL bypass_commit got=%h exp=%h", a_rd1, 32'h1234_AAAA); end

        // BYPASS=0: old value before the edge, new value after
        @(negedge clk);
        n_idle(); n_a2 = 3'd5;
        n_we = 1'b1; n_a3 = 3'd5; n_wd = 16'hBEEF; n_be = 2'b11;
        #1;
        checks++; if (n_rd2 !== 16'h0) begin failures++; $display("FAIL nobypass_old got=%h exp=%h", n_rd2, 16'h0); end
        @(negedge clk);
        n_idle(); n_a2 = 3'd5;
        #1;
        checks++; if (n_rd2 !== 16'hBEEF) begin failures++; $display("FAIL nobypass_new got=%h exp=%h", n_rd2, 16'hBEEF); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_scoreboard();
        @(negedge clk);
        a_idle(); a_a1 = 3'd6; a_rsv = 1'b1; a_rsva = 3'd6;
        #1;
        checks++; if (a_busy1 !== 1'b0) begin failures++; $display("FAIL sb_no_set_bypass got=%b exp=%b", a_busy1, 1'b0); end
        @(negedge clk);
        a_idle(); a_a1 = 3'd6; a_a2 = 3'd6;
        #1;
        checks++; if (a_busy1 !== 1'b1) begin failures++; $display("FAIL sb_set_busy1 got=%b exp=%b", a_busy1, 1'b1); end
        checks++; if (a_busy2 !== 1'b1) begin failures++; $display("FAIL sb_set_busy2 got=%b exp=%b", a_busy2, 1'b1); end
        checks++; if (a_busyall !== 8'h40) begin failures++; $display("FAIL sb_set_vec got=%h exp=%h", a_busyall, 8'h40); end

        // Re-reserve an already busy register
        @(negedge clk);
        a_idle(); a_rsv = 1'b1; a_rsva = 3'd6;
        @(negedge clk);
        a_idle();
        #1;
        checks++; if (a_busyall !== 8'h40) begin failures++; $display("FAIL sb_rersv got=%h exp=%h", a_busyall, 8'h40); end

        // Write with no lanes: clears busy, data unchanged
        @(negedge clk);
        a_idle(); a_a1 = 3'd6; a_we = 1'b1; a_a3 = 3'd6; a_wd = 32'hFFFF_FFFF; a_be = 4'b0000;
        #1;
        checks++; if (a_busy1 !== 1'b1) begin failures++; $display("FAIL sb_no_clr_bypass got=%b exp=%b", a_busy1, 1'b1); end
        checks++; if (a_rd1 !== 32'h0) begin failures++; $display("FAIL sb_be0_bypass got=%h exp=%h", a_rd1, 32'h0); end
        @(negedge clk);
        a_idle(); a_a1 = 3'd6;
        #1;
        checks++; if (a_busy1 !== 1'b0) begin failures++; $display("FAIL sb_clear got=%b exp=%b", a_busy1, 1'b0); end
        checks++; if (a_rd1 !== 32'h0) begin failures++; $display("FAIL sb_be0_data got=%h exp=%h", a_rd1, 32'h0); end

        // Reserve and write to the same register in one cycle
        @(negedge clk);
        a_idle(); a_rsv = 1'b1; a_rsva = 3'd6;
        a_we = 1'b1; a_a3 = 3'd6; a_wd = 32'h600D_600D; a_be = 4'hF;
        @(negedge clk);
        a_idle(); a_a1 = 3'd6;
        #1;
        checks++; if (a_busy1 !== 1'b1) begin failures++; $display("FAIL sb_rsv_wins got=%b exp=%b", a_busy1, 1'b1); end
        checks++; if (a_rd1 !== 32'h600D_600D) begin failures++; $display("FAIL sb_rsv_we_data got=%h exp=%h", a_rd1, 32'h600D_600D); end

        // Reserve r1 while retiring r6
        @(negedge clk);
        a_idle(); a_rsv = 1'b1; a_rsva = 3'd1;
        a_we = 1'b1; a_a3 = 3'd6; a_wd = 32'h0; a_be = 4'hF;
        @(negedge clk);
        a_idle();
        #1;
        checks++; if (a_busyall !== 8'h02) begin failures++; $display("FAIL sb_swap got=%h exp=%h", a_busyall, 8'h02); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_zero_reg();
        @(negedge clk);
        z_idle(); z_a1 = 3'd0;
        z_we = 1'b1; z_a3 = 3'd0; z_wd = 32'hFFFF_FFFF; z_be = 4'hF;
        z_rsv = 1'b1; z_rsva = 3'd0;
        #1;
        checks++; if (z_rd1 !== 32'h0) begin failures++; $display("FAIL zero_bypass got=%h exp=%h", z_rd1, 32'h0); end
        @(negedge clk);
        z_idle(); z_a1 = 3'd0;
        #1;
        checks++; if (z_rd1 !== 32'h0) begin failures++; $display("FAIL zero_data got=%h exp=%h", z_rd1, 32'h0); end
        checks++; if (z_busy1 !== 1'b0) begin failures++; $display("FAIL zero_busy1 got=%b exp=%b", z_busy1, 1'b0); end
        checks++; if (z_busyall !== 8'h00) begin failures++; $display("FAIL zero_busyall got=%h exp=%h", z_busyall, 8'h00); end

        // Register 1 in the same instance behaves normally
        @(negedge clk);
        z_idle(); z_a2 = 3'd1;
        z_we = 1'b1; z_a3 = 3'd1; z_wd = 32'hFFFF_FFFF; z_be = 4'hF;
        z_rsv = 1'b1; z_rsva = 3'd1;
        #1;
        checks++; if (z_rd2 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL zero_r1_bypass got=%h exp=%h", z_rd2, 32'hFFFF_FFFF); end
        @(negedge clk);
        z_idle(); z_a2 = 3'd1;
        #1;
        checks++; if (z_busy2 !== 1'b1) begin failures++; $display("FAIL zero_r1_busy got=%b exp=%b", z_busy2, 1'b1); end
        checks++; if (z_busyall !== 8'h02) begin failures++; $display("FAIL zero_r1_vec got=%h exp=%h", z_busyall, 8'h02); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_out_of_range();
        @(negedge clk);
        n_idle(); n_we = 1'b1; n_a3 = 3'd7; n_wd = 16'h1234; n_be = 2'b11;
        n_rsv = 1'b1; n_rsva = 3'd7;
        @(negedge clk);
        n_idle(); n_we = 1'b1; n_a3 = 3'd6; n_wd = 16'h5678; n_be = 2'b11;
        n_rsv = 1'b1; n_rsva = 3'd6;
        @(negedge clk);
        n_idle(); n_a1 = 3'd7; n_a2 = 3'd6;
        #1;
        checks++; if (n_rd1 !== 16'h0) begin failures++; $display("FAIL oor_rd1 got=%h exp=%h", n_rd1, 16'h0); end
        checks++; if (n_rd2 !== 16'h0) begin failures++; $display("FAIL oor_rd2 got=%h exp=%h", n_rd2, 16'h0); end
        checks++; if (n_busy1 !== 1'b0) begin failures++; $display("FAIL oor_busy1 got=%b exp=%b", n_busy1, 1'b0); end
        checks++; if (n_busyall !== 6'h00) begin failures++; $display("FAIL oor_busyall got=%h exp=%h", n_busyall, 6'h00); end

        for (int k = 0; k < 6; k++) begin
            logic [15:0] exp_v;
            exp_v = (k == 5) ? 16'hBEEF : 16'h0000;
            @(negedge clk);
            n_idle(); n_a2 = 3'(k);
            #1;
            checks++; if (n_rd2 !== exp_v) begin failures++; $display("FAIL oor_scan_r%0d got=%h exp=%h", k, n_rd2, exp_v); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_idle(); z_idle(); n_idle();
        test_reset();
        test_byte_lane();
        test_bypass();
        test_scoreboard();
        test_zero_reg();
        test_out_of_range();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
